imem_loader: RTL and testbench

Boot-time copier that fills the SPRAM-based instruction memory from an initialized block-RAM boot ROM after every reset. SPRAM cannot be initialized through device configuration, so the loader is the only writer of the instruction memory's write port. It holds the core stalled until the image is in place, then hands the instruction memory address port over to the core's fetch path. Optionally, it reads the image back and flags the first mismatch.

---
 rtl/imem_loader_pkg.sv | 14 +
 rtl/imem_verify_cmp.sv | 39 +++
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared state encoding and widths for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 14;
    localparam int WORD_W      = 32;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        VERIFY,
        DONE
    } loader_state_e;

endpackage

// File: rtl/imem_verify_cmp.sv
// Readback comparator: aligns the presented address with the one-cycle-late
// read data and captures the first mismatching address (sticky until clear).
module imem_verify_cmp
    import imem_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   check_en,
    input  logic [IMEM_ADDR_W-1:0] check_addr,
    input  logic [WORD_W-1:0]      rom_data,
    input  logic [WORD_W-1:0]      imem_rdata,
    output logic                   error,
    output logic [IMEM_ADDR_W-1:0] error_addr
);

    logic                   pend_q;
    logic [IMEM_ADDR_W-1:0] addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q     <= 1'b0;
            addr_q     <= '0;
            error      <= 1'b0;
            error_addr <= '0;
        end else begin
            pend_q <= check_en;
            addr_q <= check_addr;
            if (clear) begin
                error      <= 1'b0;
                error_addr <= '0;
            end else if (pend_q && !error && (rom_data != imem_rdata)) begin
                error      <= 1'b1;
                error_addr <= addr_q;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time copier from block-RAM boot ROM into SPRAM instruction memory.
// Define IMEM_LOADER_VERIFY_EN to add a readback pass with mismatch capture.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WORDS  = 4096,
    parameter int ROM_AW = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reload,
    output logic                   rom_rd_en,
    output logic [ROM_AW-1:0]      rom_addr,
    input  logic [WORD_W-1:0]      rom_data,
    input  logic [IMEM_ADDR_W-1:0] core_addr,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic                   imem_wr_en,
    output logic [WORD_W-1:0]      imem_wdata,
    input  logic [WORD_W-1:0]      imem_rdata,
    output logic                   core_stall,
    output logic                   done,
    output logic                   error,
    output logic [IMEM_ADDR_W-1:0] error_addr
);

    localparam int CNT_W = ROM_AW + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS);

    loader_state_e          state;
    logic [CNT_W-1:0]       cnt;
    logic                   rd_en_q;
    logic [ROM_AW-1:0]      rom_addr_q;
    logic                   wr_en_q;
    logic [IMEM_ADDR_W-1:0] wr_addr_q;
    logic                   done_q;
    logic [IMEM_ADDR_W-1:0] loader_addr;

    // Each pass (copy or verify) ends in the first cycle with no ROM read
    // outstanding; the extra cycle lets the last read's data be consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_en_q    <= 1'b0;
            rom_addr_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= COPY;
                    rd_en_q    <= 1'b1;
                    rom_addr_q <= '0;
                    cnt        <= CNT_ONE;
                    wr_en_q    <= 1'b0;
                end
                COPY: begin
                    wr_en_q   <= rd_en_q;
                    wr_addr_q <= IMEM_ADDR_W'(rom_addr_q);
                    if (cnt < CNT_LAST) begin
                        rd_en_q    <= 1'b1;
                        rom_addr_q <= cnt[ROM_AW-1:0];
                        cnt        <= cnt + CNT_ONE;
                    end else begin
                        rd_en_q <= 1'b0;
                    end
                    if (!rd_en_q) begin
                        wr_en_q <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
                        state      <= VERIFY;
                        rd_en_q    <= 1'b1;
                        rom_addr_q <= '0;
                        cnt        <= CNT_ONE;
`else
                        state  <= DONE;
                        done_q <= 1'b1;
`endif
                    end
                end
                VERIFY: begin
                    if (cnt < CNT_LAST) begin
                        rd_en_q    <= 1'b1;
                        rom_addr_q <= cnt[ROM_AW-1:0];
                        cnt        <= cnt + CNT_ONE;
                    end else begin
                        rd_en_q <= 1'b0;
                    end
                    if (!rd_en_q) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (reload) begin
                        state      <= COPY;
                        done_q     <= 1'b0;
                        rd_en_q    <= 1'b1;
                        rom_addr_q <= '0;
                        cnt        <= CNT_ONE;
                        wr_en_q    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        loader_addr = wr_addr_q;
        if (state == VERIFY) begin
            loader_addr = IMEM_ADDR_W'(rom_addr_q);
        end
    end

    assign rom_rd_en  = rd_en_q;
    assign rom_addr   = rom_addr_q;
    assign imem_addr  = done_q ? core_addr : loader_addr;
    assign imem_wr_en = wr_en_q;
    assign imem_wdata = wr_en_q ? rom_data : '0;
    assign core_stall = !done_q;
    assign done       = done_q;

`ifdef IMEM_LOADER_VERIFY_EN
    logic check_en;
    logic check_clear;

    assign check_en    = rd_en_q && (state == VERIFY);
    assign check_clear = (state == DONE) && reload;

    imem_verify_cmp u_verify_cmp (
        .clk        (clk),
        .reset      (reset),
        .clear      (check_clear),
        .check_en   (check_en),
        .check_addr (IMEM_ADDR_W'(rom_addr_q)),
        .rom_data   (rom_data),
        .imem_rdata (imem_rdata),
        .error      (error),
        .error_addr (error_addr)
    );
`else
    logic unused_rdata;

    assign unused_rdata = ^imem_rdata;
    assign error        = 1'b0;
    assign error_addr   = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a cycle-indexed timeline model.
// Build with IMEM_LOADER_VERIFY_EN defined to exercise the readback pass.
module tb_imem_loader;

    localparam int W  = 4;
    localparam int AW = 2;
`ifdef IMEM_LOADER_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif
    localparam int DONE_CYC = VERIFY_ON ? 2 * W + 3 : W + 2;

    logic          clk;
    logic          reset;
    logic          reload;
    logic          rom_rd_en;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic [13:0]   core_addr;
    logic [13:0]   imem_addr;
    logic          imem_wr_en;
    logic [31:0]   imem_wdata;
    logic [31:0]   imem_rdata;
    logic          core_stall;
    logic          done;
    logic          error;
    logic [13:0]   error_addr;

    logic [31:0] rom_img [0:W-1];
    logic [31:0] mem [0:16383];
    bit          fault;

    int          c;          // spec cycle index of the current cycle, -1 while in reset
    bit          prev_done;
    logic [13:0] prev_ca;
    int          n_checks;
    int          n_errors;

    imem_loader #(.WORDS(W), .ROM_AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .reload     (reload),
        .rom_rd_en  (rom_rd_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .core_addr  (core_addr),
        .imem_addr  (imem_addr),
        .imem_wr_en (imem_wr_en),
        .imem_wdata (imem_wdata),
        .imem_rdata (imem_rdata),
        .core_stall (core_stall),
        .done       (done),
        .error      (error),
        .error_addr (error_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Boot ROM and SPRAM, both one-cycle read latency; SPRAM can flip bit 0 of word 2.
    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= rom_img[rom_addr];
    end

    always @(posedge clk) begin
        if (imem_wr_en) mem[imem_addr] <= imem_wdata;
        imem_rdata <= mem[imem_addr] ^ ((fault && imem_addr == 14'd2) ? 32'h1 : 32'h0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, c);
        end
    endtask

    function automatic logic [31:0] spram_word(input logic [13:0] a);
        logic [31:0] w;
        w = rom_img[a[AW-1:0]];
        if (fault && a == 14'd2) w = w ^ 32'h1;
        return w;
    endfunction

    function automatic logic [13:0] rand_ca();
        if ($urandom_range(0, 3) == 0) return 14'($urandom);
        return 14'($urandom_range(0, W - 1));
    endfunction

    task automatic check_outputs();
        bit exp_done, exp_wr, copy_rd, ver_rd, exp_err;
        if (c < 0) begin
            chk("rst_stall", core_stall, 1);
            chk("rst_done", done, 0);
            chk("rst_rd_en", rom_rd_en, 0);
            chk("rst_rom_addr", rom_addr, 0);
            chk("rst_wr_en", imem_wr_en, 0);
            chk("rst_wdata", imem_wdata, 0);
            chk("rst_error", error, 0);
            chk("rst_error_addr", error_addr, 0);
        end else begin
            exp_done = (c == DONE_CYC);
            exp_wr   = (c >= 2 && c <= W + 1);
            copy_rd  = (c >= 1 && c <= W);
            ver_rd   = VERIFY_ON && (c >= W + 2 && c <= 2 * W + 1);
            exp_err  = VERIFY_ON && fault;
            chk("done", done, exp_done);
            chk("core_stall", core_stall, !exp_done);
            chk("rom_rd_en", rom_rd_en, copy_rd || ver_rd);
            if (copy_rd) chk("copy_rom_addr", rom_addr, c - 1);
            if (ver_rd) begin
                chk("ver_rom_addr", rom_addr, c - (W + 2));
                chk("ver_imem_addr", imem_addr, c - (W + 2));
            end
            chk("imem_wr_en", imem_wr_en, exp_wr);
            if (exp_wr) begin
                chk("wr_addr", imem_addr, c - 2);
                chk("wr_data", imem_wdata, rom_img[c - 2]);
            end else begin
                chk("wdata_gated", imem_wdata, 0);
            end
            if (c <= W + 2) chk("error_clear", error, 0);
            if (exp_done) begin
                chk("handover_addr", imem_addr, core_addr);
                chk("error", error, exp_err);
                chk("error_addr", error_addr, exp_err ? 2 : 0);
            end
            if (prev_done && prev_ca < W) chk("fetch_rdata", imem_rdata, spram_word(prev_ca));
        end
    endtask

    // Advance one clock: update the timeline from the inputs held last cycle,
    // drive this cycle's inputs just after the edge, check on the falling edge.
    task automatic tick(input bit rs, input bit rl, input logic [13:0] ca, input bit reimg);
        @(posedge clk);
        prev_done = (c == DONE_CYC);
        prev_ca   = core_addr;
        if (rs)                 c = -1;
        else if (c == -1)       c = 0;
        else if (c == DONE_CYC) c = reload ? 1 : DONE_CYC;
        else                    c = c + 1;
        #1;
        reset     = rs;
        reload    = rl;
        core_addr = ca;
        if (rs && reimg) begin
            for (int i = 0; i < W; i++) rom_img[i] = $urandom;
            fault = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, rand_ca(), 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        c         = -1;
        prev_done = 1'b0;
        prev_ca   = '0;
        fault     = 1'b0;
        reset     = 1'b1;
        reload    = 1'b0;
        core_addr = '0;
        rom_img[0] = 32'h0000_0013;
        rom_img[1] = 32'h0010_0093;
        rom_img[2] = 32'h0020_8113;
        rom_img[3] = 32'h0000_006F;

        repeat (3) tick(1'b1, 1'b0, 14'd0, 1'b0);
        check_outputs();
        run(DONE_CYC + 2);
        tick(1'b0, 1'b0, 14'h0003, 1'b0);
        tick(1'b0, 1'b0, 14'h0003, 1'b0);

        // reload in DONE, then a stray pulse in COPY cycle 2
        tick(1'b0, 1'b1, rand_ca(), 1'b0);
        tick(1'b0, 1'b0, rand_ca(), 1'b0);
        tick(1'b0, 1'b1, rand_ca(), 1'b0);
        run(DONE_CYC + 2);

        // reset in cycle 3 of a fresh copy, new image with the faulty SPRAM word
        tick(1'b1, 1'b0, 14'd0, 1'b0);
        run(3);
        tick(1'b1, 1'b0, 14'd0, 1'b1);
        fault = 1'b1;
        tick(1'b1, 1'b0, 14'd0, 1'b0);
        run(DONE_CYC + 4);
        tick(1'b0, 1'b1, rand_ca(), 1'b0);
        run(DONE_CYC + 2);

        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0), rand_ca(), 1'b1);
        end
        tick(1'b1, 1'b0, 14'd0, 1'b1);
        run(DONE_CYC + 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
